job_responder: RTL

Synthesizable responder for the start/done job handshake driven by the bench initializer. On a one-cycle `start` pulse it latches a job length, streams that many words from a synchronous read port, accumulates their sum, and raises a level `done` with the result. It sits as the DUT-side endpoint under test, between the initializer (start/done) and a simple memory model (read port).

---
 rtl/job_pkg.sv | 16 +
 rtl/job_addr_counter.sv | 35 +++
 rtl/job_responder.sv | 94 +++++++++
 3 files changed

// File: rtl/job_pkg.sv
// job_pkg: shared state encoding and default parameters for the job responder.
package job_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } job_state_t;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;
    localparam int RD_LAT     = 1;

endpackage

// File: rtl/job_addr_counter.sv
// job_addr_counter: remaining-word down-counter with an up-running read address.
module job_addr_counter
    import job_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] rem_q, addr_q;

    assign addr_o = addr_q;
    assign last_o = step_i && rem_q == ADDR_W'(1);

    // The address holds on the final issue so a full-range job never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            addr_q <= '0;
        end else if (load_i) begin
            rem_q  <= len_i;
            addr_q <= '0;
        end else if (step_i) begin
            rem_q  <= rem_q - ADDR_W'(1);
            addr_q <= last_o ? addr_q : addr_q + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/job_responder.sv
// job_responder: start/done job endpoint that streams len words from a
// synchronous read port and returns their modular sum.
module job_responder
    import job_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              overrun
);

    job_state_t        state_q;
    logic [RD_LAT-1:0] vld_q;
    logic [ACC_W-1:0]  acc_q, acc_d, result_q;
    logic              rd_en_q, busy_q, done_q, overrun_q;
    logic              accept, load, last;

    assign accept  = start && (state_q == IDLE || state_q == DONE);
    assign load    = accept && len != '0;
    assign rd_en   = rd_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign overrun = overrun_q;

    // A word is added when the read issued RD_LAT cycles earlier returns.
    always_comb acc_d = vld_q[RD_LAT-1] ? acc_q + ACC_W'(rd_data) : acc_q;

    job_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .len_i  (len),
        .step_i (state_q == READ),
        .addr_o (rd_addr),
        .last_o (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vld_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            vld_q <= RD_LAT'({vld_q, rd_en_q});
            acc_q <= acc_d;
            if (start && busy_q)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        acc_q     <= '0;
                        result_q  <= '0;
                        overrun_q <= 1'b0;
                        done_q    <= !load;
                        rd_en_q   <= load;
                        busy_q    <= load;
                        state_q   <= load ? READ : DONE;
                    end
                end
                READ: begin
                    if (last) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= acc_d;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
